// File: rtl/inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetcher
// Purpose  : Instruction-fetch stage. Holds the PC and a direct-mapped,
//            one-word-per-line instruction cache. Hits are delivered to the
//            instruction queue at one per cycle. A miss raises a level-held
//            request to the memory controller until it reports done. The
//            next PC is predicted as PC+4, and the ROB corrects it with a
//            jump/flush redirect.
// Ports    : clk, rst (async, active-low), rdy (global enable)
//            iJMP_en/iJMP_pc    - redirect from the ROB
//            iIQ_full           - instruction queue back-pressure
//            oIQ_valid/inst/pc  - registered instruction output (pulse)
//            oMC_en/oMC_addr    - registered fetch request (level-held)
//            iMC_done/iMC_inst  - refill completion pulse and data word
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetcher #(
    parameter int          IDX_W    = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        iJMP_en,
    input  logic [31:0] iJMP_pc,
    input  logic        iIQ_full,
    output logic        oIQ_valid,
    output logic [31:0] oIQ_inst,
    output logic [31:0] oIQ_pc,
    output logic        oMC_en,
    output logic [31:0] oMC_addr,
    input  logic        iMC_done,
    input  logic [31:0] iMC_inst
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [0:0] {
        LOOKUP = 1'b0,
        MISS   = 1'b1
    } state_t;

    state_t            state;
    logic              discard;
    logic [31:0]       pc;
    logic [LINES-1:0]  line_valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [IDX_W-1:0]  lookup_idx;
    logic [TAG_W-1:0]  lookup_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              fill;

    assign lookup_idx = pc[IDX_W+1:2];
    assign lookup_tag = pc[31:IDX_W+2];
    // The refill address is the held request address, not the (possibly
    // redirected) PC.
    assign fill_idx   = oMC_addr[IDX_W+1:2];
    assign fill_tag   = oMC_addr[31:IDX_W+2];
    assign hit        = line_valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign fill       = rdy && (state == MISS) && iMC_done;

    // Tag/data arrays carry no reset: only the valid bits need clearing,
    // and fill can never be true while reset holds the FSM in LOOKUP.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iMC_inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOOKUP;
            discard    <= 1'b0;
            pc         <= RESET_PC;
            line_valid <= '0;
            oIQ_valid  <= 1'b0;
            oIQ_inst   <= 32'h0;
            oIQ_pc     <= 32'h0;
            oMC_en     <= 1'b0;
            oMC_addr   <= 32'h0;
        end else if (rdy) begin
            oIQ_valid <= 1'b0;
            case (state)
                LOOKUP: begin
                    if (iJMP_en) begin
                        pc <= iJMP_pc;
                    end else if (iIQ_full) begin
                        pc <= pc;
                    end else if (hit) begin
                        oIQ_valid <= 1'b1;
                        oIQ_inst  <= data_mem[lookup_idx];
                        oIQ_pc    <= pc;
                        pc        <= pc + 32'd4;
                    end else begin
                        oMC_en   <= 1'b1;
                        oMC_addr <= pc;
                        state    <= MISS;
                    end
                end
                MISS: begin
                    if (iMC_done) begin
                        line_valid[fill_idx] <= 1'b1;
                        oMC_en  <= 1'b0;
                        state   <= LOOKUP;
                        discard <= 1'b0;
                        if (iJMP_en) begin
                            // Redirect coinciding with done: keep the fill,
                            // drop the word, take the new target.
                            pc <= iJMP_pc;
                        end else if (!discard) begin
                            // Refill output bypasses iIQ_full; the queue
                            // keeps a one-slot margin for this case.
                            oIQ_valid <= 1'b1;
                            oIQ_inst  <= iMC_inst;
                            oIQ_pc    <= oMC_addr;
                            pc        <= oMC_addr + 32'd4;
                        end
                    end else if (iJMP_en) begin
                        // Keep the request alive so the controller's
                        // sequencing stays intact; just drop its result.
                        pc      <= iJMP_pc;
                        discard <= 1'b1;
                    end
                end
                default: state <= LOOKUP;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetcher
// Purpose  : Self-checking bench for inst_fetcher. Directed scenarios followed
//            by randomized redirects, back-pressure, enable gaps and memory
//            latency, all compared against a transaction-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetcher;

    localparam int IDX_W = 6;
    localparam int LINES = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        iJMP_en;
    logic [31:0] iJMP_pc;
    logic        iIQ_full;
    logic        oIQ_valid;
    logic [31:0] oIQ_inst;
    logic [31:0] oIQ_pc;
    logic        oMC_en;
    logic [31:0] oMC_addr;
    logic        iMC_done;
    logic [31:0] iMC_inst;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    // Reference state: expected fetch PC, outstanding request, cache contents
    logic [31:0] exp_pc;
    logic        busy;
    logic        stale;
    logic [31:0] req_addr;
    bit          mv [LINES];
    logic [29:0] ma [LINES];

    inst_fetcher #(.IDX_W(IDX_W), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iJMP_en(iJMP_en), .iJMP_pc(iJMP_pc), .iIQ_full(iIQ_full),
        .oIQ_valid(oIQ_valid), .oIQ_inst(oIQ_inst), .oIQ_pc(oIQ_pc),
        .oMC_en(oMC_en), .oMC_addr(oMC_addr),
        .iMC_done(iMC_done), .iMC_inst(iMC_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0) return 32'h00500093;
        return (w * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'(a[31:2] % LINES);
    endfunction

    function automatic bit mhit(input logic [31:0] a);
        return mv[line_of(a)] && (ma[line_of(a)] == a[31:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc = 32'h0;
        busy   = 1'b0;
        stale  = 1'b0;
        req_addr = 32'h0;
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endtask

    // One clock: apply inputs, advance, then compare against the reference.
    task automatic step(input logic j, input logic [31:0] jp, input logic f,
                        input logic d, input logic r);
        logic        s_v, s_en, eo;
        logic [31:0] s_inst, s_pc, s_addr, eop;
        s_v = oIQ_valid; s_inst = oIQ_inst; s_pc = oIQ_pc;
        s_en = oMC_en;   s_addr = oMC_addr;
        iJMP_en = j; iJMP_pc = jp; iIQ_full = f; iMC_done = d; rdy = r;
        iMC_inst = mem(oMC_addr);
        @(posedge clk);
        #1;
        if (!r) begin
            chk("hold_valid", oIQ_valid, s_v);
            chk("hold_inst",  oIQ_inst,  s_inst);
            chk("hold_pc",    oIQ_pc,    s_pc);
            chk("hold_en",    oMC_en,    s_en);
            chk("hold_addr",  oMC_addr,  s_addr);
        end else begin
            eo = 1'b0; eop = 32'h0;
            if (!busy) begin
                if (j) exp_pc = jp;
                else if (!f) begin
                    if (mhit(exp_pc)) begin
                        eo = 1'b1; eop = exp_pc; exp_pc = exp_pc + 32'd4;
                    end else begin
                        busy = 1'b1; stale = 1'b0; req_addr = exp_pc;
                    end
                end
            end else if (d) begin
                mv[line_of(req_addr)] = 1'b1;
                ma[line_of(req_addr)] = req_addr[31:2];
                busy = 1'b0;
                if (j) exp_pc = jp;
                else if (!stale) begin
                    eo = 1'b1; eop = req_addr; exp_pc = req_addr + 32'd4;
                end
            end else if (j) begin
                exp_pc = jp; stale = 1'b1;
            end
            chk("iq_valid", oIQ_valid, eo);
            if (eo) begin
                n_out++;
                chk("iq_pc",   oIQ_pc,   eop);
                chk("iq_inst", oIQ_inst, mem(eop));
            end
            chk("mc_en", oMC_en, busy);
            if (busy) chk("mc_addr", oMC_addr, req_addr);
        end
        iMC_done = 1'b0;
        iJMP_en  = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mc_en",   oMC_en,    0);
        chk("rst_mc_addr", oMC_addr,  0);
        chk("rst_valid",   oIQ_valid, 0);
        chk("rst_inst",    oIQ_inst,  0);
        chk("rst_pc",      oIQ_pc,    0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; iJMP_en = 1'b0; iJMP_pc = 32'h0;
        iIQ_full = 1'b0; iMC_done = 1'b0; iMC_inst = 32'h0;
        model_reset();
        async_reset();

        // Cold start
        step(0, 0, 0, 0, 1);
        chk("cold_en", oMC_en, 1);
        chk("cold_addr", oMC_addr, 32'h0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("cold_out", oIQ_valid, 1);
        chk("cold_inst", oIQ_inst, 32'h00500093);
        step(0, 0, 0, 0, 1);
        chk("next_miss_addr", oMC_addr, 32'h4);
        step(0, 0, 0, 1, 1);

        // Loop back to 0 hits with no request
        step(1, 32'h0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("loop_valid", oIQ_valid, 1);
        chk("loop_inst", oIQ_inst, 32'h00500093);
        chk("loop_no_req", oMC_en, 0);

        // Queue full for 3 cycles, then resume at same pc
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("full_resume_pc", oIQ_pc, 32'h4);

        // Redirect during miss at 0x8 to 0x100
        step(0, 0, 0, 0, 1);
        chk("redir_miss_addr", oMC_addr, 32'h8);
        step(1, 32'h100, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("redir_no_out", oIQ_valid, 0);
        step(0, 0, 0, 0, 1);
        chk("redir_new_addr", oMC_addr, 32'h100);
        step(0, 0, 0, 1, 1);
        step(1, 32'h8, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("redir_8_hits", oIQ_valid, 1);

        // 0x100 replaced the line of 0x0
        step(1, 32'h0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("alias_miss", oMC_en, 1);
        step(0, 0, 0, 1, 1);

        // rdy low mid-miss, done arrives after rdy returns
        step(1, 32'h200, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("rdy_done_pc", oIQ_pc, 32'h200);

        // Reset mid-miss
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        async_reset();
        step(0, 0, 0, 0, 1);
        chk("post_rst_addr", oMC_addr, 32'h0);
        step(0, 0, 0, 1, 1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic        j, f, d, r;
            logic [31:0] jp;
            j  = ($urandom % 16) == 0;
            jp = {$urandom_range(0, 255), 2'b00};
            if (($urandom % 8) == 0) jp = 32'hFFFF_FFF8;
            f  = ($urandom % 5) == 0;
            d  = oMC_en && (($urandom % 3) == 0);
            r  = ($urandom % 10) != 0;
            step(j, jp, f, d, r);
        end
        chk("stream_progress", (n_out > 300) ? 32'd1 : 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
